// File: rtl/dx_bypass_stage_pkg.sv
// Shared types and default widths for the D/X bypass stage.
// Forwarding bus payload plus the widths used when the top is built with defaults.
package dx_bypass_stage_pkg;

  localparam int unsigned DX_DATA_W  = 32;
  localparam int unsigned DX_ADDR_W  = 5;
  localparam int unsigned DX_STALL_W = 16;

  // One forwarding stage as seen by the bypass network.
  typedef struct packed {
    logic                 we;
    logic                 rdy;
    logic [DX_ADDR_W-1:0] addr;
    logic [DX_DATA_W-1:0] data;
  } fwd_bus_t;

endpackage

// File: rtl/dx_bypass_stage_fwd_select.sv
// Priority forwarding select for one source operand: the youngest matching stage wins.
// With DX_ZERO_REG_EN defined, address 0 never matches and always reads as zero.
module fwd_select
  import dx_bypass_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DX_DATA_W,
  parameter int unsigned ADDR_W  = DX_ADDR_W,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic [ADDR_W-1:0]         src_addr,
  input  logic [DATA_W-1:0]         held_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         data,
  output logic                      hit,
  output logic                      pending
);

  always_comb begin
    data    = held_data;
    hit     = 1'b0;
    pending = 1'b0;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      if (!hit && fwd_we[i] && (fwd_addr[i*ADDR_W +: ADDR_W] == src_addr)) begin
        hit     = 1'b1;
        pending = !fwd_rdy[i];
        if (fwd_rdy[i]) begin
          data = fwd_data[i*DATA_W +: DATA_W];
        end
      end
    end
`ifdef DX_ZERO_REG_EN
    if (src_addr == '0) begin
      data    = '0;
      hit     = 1'b0;
      pending = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/dx_bypass_stage.sv
// Decode-to-execute ready/valid register with operand bypass, load-use stall and refresh.
// Optional DX_ZERO_REG_EN hardwires source register 0 to zero.
module dx_bypass_stage
  import dx_bypass_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = DX_DATA_W,
  parameter int unsigned ADDR_W    = DX_ADDR_W,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_FWD   = 3,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] in_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
  input  logic [ADDR_W-1:0]         in_dst_addr,
  input  logic                      in_dst_we,
  input  logic                      in_is_load,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SRC*DATA_W-1:0] out_src_data,
  output logic [ADDR_W-1:0]         out_dst_addr,
  output logic                      out_dst_we,
  output logic                      out_is_load,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [DX_STALL_W-1:0]     stall_cycles
);

  logic                      held_valid;
  logic [NUM_SRC*ADDR_W-1:0] held_src_addr;
  logic [NUM_SRC*DATA_W-1:0] held_src_data;
  logic [NUM_SRC*DATA_W-1:0] sel_data;
  logic [NUM_SRC*DATA_W-1:0] cap_data;
  logic [NUM_SRC-1:0]        sel_hit;
  logic [NUM_SRC-1:0]        sel_pending;
  logic                      hazard;
  logic                      fire;
  logic                      accept;

  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
    fwd_select #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_FWD(NUM_FWD)
    ) u_fwd_select (
      .src_addr (held_src_addr[g*ADDR_W +: ADDR_W]),
      .held_data(held_src_data[g*DATA_W +: DATA_W]),
      .fwd_we   (fwd_we),
      .fwd_addr (fwd_addr),
      .fwd_rdy  (fwd_rdy),
      .fwd_data (fwd_data),
      .data     (sel_data[g*DATA_W +: DATA_W]),
      .hit      (sel_hit[g]),
      .pending  (sel_pending[g])
    );
  end

  assign hazard       = held_valid && (|sel_pending);
  assign out_valid    = held_valid && !hazard;
  assign fire         = out_valid && out_ready;
  assign in_ready     = !held_valid || fire;
  assign accept       = in_valid && in_ready;
  assign out_src_data = {(NUM_SRC*DATA_W){held_valid}} & sel_data;

  // Operand values captured from the register file on accept.
`ifdef DX_ZERO_REG_EN
  always_comb begin
    cap_data = in_src_data;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (in_src_addr[s*ADDR_W +: ADDR_W] == '0) begin
        cap_data[s*DATA_W +: DATA_W] = '0;
      end
    end
  end
`else
  assign cap_data = in_src_data;
`endif

  // Held instruction: flush beats accept; waiting operands track the forwarding buses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid    <= 1'b0;
      held_src_addr <= '0;
      held_src_data <= '0;
      out_dst_addr  <= '0;
      out_dst_we    <= 1'b0;
      out_is_load   <= 1'b0;
      out_payload   <= '0;
      stall_cycles  <= '0;
    end else begin
      if (flush) begin
        held_valid <= 1'b0;
      end else if (accept) begin
        held_valid <= 1'b1;
      end else if (fire) begin
        held_valid <= 1'b0;
      end

      if (accept && !flush) begin
        held_src_addr <= in_src_addr;
        held_src_data <= cap_data;
        out_dst_addr  <= in_dst_addr;
        out_dst_we    <= in_dst_we;
        out_is_load   <= in_is_load;
        out_payload   <= in_payload;
      end else if (held_valid && !fire) begin
        for (int s = 0; s < int'(NUM_SRC); s++) begin
          if (sel_hit[s] && !sel_pending[s]) begin
            held_src_data[s*DATA_W +: DATA_W] <= sel_data[s*DATA_W +: DATA_W];
          end
        end
      end

      if (hazard && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + DX_STALL_W'(1);
      end
    end
  end

endmodule
